morse_decoder: RTL
==================

Name: morse_decoder

Overview:
- Datapath stage directly downstream of texter_control.
- Accumulates dit/dash symbols on each nxt_bit pulse and continuously reports dc_error when the accumulated pattern is not a legal Morse character.
- On nxt_char, translates the pattern to ASCII, presents it for one cycle to the display/character buffer, then clears itself for the next character.

Parameters:
- ERR_CHAR, 8'h2A, ASCII code reported on char_code when a decode is attempted on an illegal pattern.
- CODE_W, 8, width of char_code.

Ports:
- clk  input  1  system clock (27 MHz on DE-2), all state changes on rising edge.
- reset  input  1  synchronous, active-low; when 0 at a rising edge, block returns to empty state.
- nxt_bit  input  1  one-cycle pulse from texter_control: append the symbol given by dash_dit.
- dash_dit  input  1  symbol type sampled with nxt_bit: 1 = dash, 0 = dit.
- nxt_char  input  1  one-cycle pulse from texter_control: decode and clear.
- dc_error  output  1  status to texter_control: 1 = current pattern not decodable.
- sym_cnt  output  3  number of symbols currently held (0..MAX_SYM).
- char_code  output  CODE_W  last decoded ASCII character (held).
- char_valid  output  1  one-cycle pulse: char_code updated with a legal character.

Behaviour:
- State: sym_reg[5:0], cnt[2:0], ovf flag, char_code, char_valid. MAX_SYM = 5 (6 with PUNCT_EN).
- Reset (reset==0 at edge): sym_reg=0, cnt=0, ovf=0, char_code=8'h20, char_valid=0. Reset beats every other input, including mid-character.
- Append (nxt_bit=1, nxt_char=0): if cnt<MAX_SYM, sym_reg <= {sym_reg[4:0], dash_dit}, cnt <= cnt+1. If cnt==MAX_SYM, ovf <= 1, sym_reg and cnt unchanged; further bits keep ovf=1.
- Pattern order: first symbol entered is the most significant of the cnt valid LSBs. Lookup key = {cnt, sym_reg}.
- dc_error: Moore output from registered state only; no combinational path from inputs. dc_error = ovf | (cnt==0) | (lookup miss). It is valid the cycle after the nxt_bit edge, which texter_control relies on.
- Decode (nxt_char=1):
  - If dc_error==0: char_code <= lookup result, char_valid <= 1 for exactly one cycle.
  - If dc_error==1: char_code <= ERR_CHAR, char_valid stays 0.
  - In both cases, the next cycle has sym_reg=0, cnt=0, ovf=0.
- Simultaneous nxt_bit and nxt_char: nxt_char has priority; the bit is discarded.
- char_valid is 0 in every cycle not immediately following a successful decode.
- Lookup table: A-Z (1-4 symbols) and 0-9 (5 symbols), uppercase ASCII. All other {cnt, pattern} combinations are misses.
- Idle with no pulses: all registers hold.

Optional Feature:
- Macro: MORSE_PUNCT_EN.
- Defined:
  - MAX_SYM = 6.
  - Table adds '.' (.-.-.-), ',' (--..--), '?' (..--..), '/' (-..-.).
  - A 7th bit sets ovf.
- Undefined:
  - MAX_SYM = 5.
  - A 6th bit sets ovf.
  - The punctuation patterns above decode as errors (the 6-symbol ones via ovf, '/' via lookup miss).

Decomposition:
- Package morse_pkg:
  - MAX_SYM constant, conditioned on MORSE_PUNCT_EN.
  - Symbol encoding constants SYM_DIT=0, SYM_DASH=1.
  - ASCII constants (ASCII_SPACE, ERR default).
  - Key width constant.
- Sub-module morse_lut:
  - Purely combinational ROM with inputs cnt[2:0] and sym[5:0], outputs ascii[7:0] and hit.
  - Instantiated once; all sequential logic stays in morse_decoder.

Test Plan:
1. Reset low 2 cycles then high; nxt_bit dit, nxt_bit dash, nxt_char -> dc_error 1 before the first bit, 0 after the second; char_code=8'h41, char_valid high exactly 1 cycle; cnt=0 after.
2. Five dash pulses, nxt_char -> char_code=8'h30 ('0'), char_valid pulse; four dashes then nxt_char -> dc_error=1 beforehand (miss), char_code=ERR_CHAR, no char_valid.
3. Six dits without MORSE_PUNCT_EN -> ovf/dc_error=1 after the 6th, sym_cnt stays 5; nxt_char -> char_code=8'h2A, char_valid 0, state cleared. With MORSE_PUNCT_EN, .-.-.- -> char_code=8'h2E.
4. nxt_char with empty accumulator -> dc_error=1, char_code=ERR_CHAR, no char_valid.
5. nxt_bit (dash) and nxt_char in the same cycle after a single dit -> decodes 'E' (8'h45); the dash is dropped; cnt=0 next cycle.
6. Reset asserted after three symbols, concurrent with nxt_char -> no char_valid, char_code=8'h20, cnt=0, dc_error=1.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants for the Morse decoder: symbol encoding, ASCII codes, depth limit.
// MORSE_PUNCT_EN raises the symbol limit to 6 and enables the punctuation table entries.
package morse_pkg;

    localparam logic SYM_DIT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

`ifdef MORSE_PUNCT_EN
    localparam logic [2:0] MAX_SYM = 3'd6;
`else
    localparam logic [2:0] MAX_SYM = 3'd5;
`endif

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h2A;

    // Lookup key is {count, pattern}
    localparam int KEY_W = 9;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse ROM: {cnt, sym} -> uppercase ASCII plus hit flag.
// Punctuation entries are present only when MORSE_PUNCT_EN is defined.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] cnt,
    input  logic [5:0] sym,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [KEY_W-1:0] key;

    assign key = {cnt, sym};

    // First symbol entered is the MSB of the cnt valid LSBs; dash = 1.
    always_comb begin
        ascii = 8'h00;
        case (key)
            9'b001_000000: ascii = "E";
            9'b001_000001: ascii = "T";
            9'b010_000000: ascii = "I";
            9'b010_000001: ascii = "A";
            9'b010_000010: ascii = "N";
            9'b010_000011: ascii = "M";
            9'b011_000000: ascii = "S";
            9'b011_000001: ascii = "U";
            9'b011_000010: ascii = "R";
            9'b011_000011: ascii = "W";
            9'b011_000100: ascii = "D";
            9'b011_000101: ascii = "K";
            9'b011_000110: ascii = "G";
            9'b011_000111: ascii = "O";
            9'b100_000000: ascii = "H";
            9'b100_000001: ascii = "V";
            9'b100_000010: ascii = "F";
            9'b100_000100: ascii = "L";
            9'b100_000110: ascii = "P";
            9'b100_000111: ascii = "J";
            9'b100_001000: ascii = "B";
            9'b100_001001: ascii = "X";
            9'b100_001010: ascii = "C";
            9'b100_001011: ascii = "Y";
            9'b100_001100: ascii = "Z";
            9'b100_001101: ascii = "Q";
            9'b101_000000: ascii = "5";
            9'b101_000001: ascii = "4";
            9'b101_000011: ascii = "3";
            9'b101_000111: ascii = "2";
            9'b101_001111: ascii = "1";
            9'b101_010000: ascii = "6";
            9'b101_011000: ascii = "7";
            9'b101_011100: ascii = "8";
            9'b101_011110: ascii = "9";
            9'b101_011111: ascii = "0";
`ifdef MORSE_PUNCT_EN
            9'b101_010010: ascii = "/";
            9'b110_010101: ascii = ".";
            9'b110_110011: ascii = ",";
            9'b110_001100: ascii = "?";
`endif
            default:       ascii = 8'h00;
        endcase
    end

    // No table entry maps to NUL, so a nonzero code marks a hit.
    assign hit = |ascii;

endmodule

// File: rtl/morse_decoder.sv
// Accumulates dit/dash symbols, flags undecodable patterns, and emits ASCII on nxt_char.
// MORSE_PUNCT_EN (via morse_pkg/morse_lut) extends depth to 6 symbols and adds punctuation.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int                 CODE_W   = 8,
    parameter logic [CODE_W-1:0]  ERR_CHAR = CODE_W'(8'h2A)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nxt_bit,
    input  logic              dash_dit,
    input  logic              nxt_char,
    output logic              dc_error,
    output logic [2:0]        sym_cnt,
    output logic [CODE_W-1:0] char_code,
    output logic              char_valid
);

    logic [5:0]        sym_q, sym_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [CODE_W-1:0] char_code_q, char_code_d;
    logic              char_valid_q, char_valid_d;

    logic [7:0]        lut_ascii;
    logic              lut_hit;
    logic              err;

    morse_lut u_lut (
        .cnt   (cnt_q),
        .sym   (sym_q),
        .ascii (lut_ascii),
        .hit   (lut_hit)
    );

    // Derived only from registered state so texter_control sees no input-to-output path.
    assign err = ovf_q | (cnt_q == 3'd0) | ~lut_hit;

    always_comb begin
        sym_d        = sym_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        char_code_d  = char_code_q;
        char_valid_d = 1'b0;

        if (nxt_char) begin
            if (!err) begin
                char_code_d  = CODE_W'(lut_ascii);
                char_valid_d = 1'b1;
            end else begin
                char_code_d  = ERR_CHAR;
            end
            sym_d = 6'd0;
            cnt_d = 3'd0;
            ovf_d = 1'b0;
        end else if (nxt_bit) begin
            if (cnt_q < MAX_SYM) begin
                sym_d = {sym_q[4:0], dash_dit};
                cnt_d = cnt_q + 3'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sym_q        <= 6'd0;
            cnt_q        <= 3'd0;
            ovf_q        <= 1'b0;
            char_code_q  <= CODE_W'(ASCII_SPACE);
            char_valid_q <= 1'b0;
        end else begin
            sym_q        <= sym_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            char_code_q  <= char_code_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign dc_error   = err;
    assign sym_cnt    = cnt_q;
    assign char_code  = char_code_q;
    assign char_valid = char_valid_q;

endmodule
